// File: rtl/fp16_neuron_acc.sv
// Sequential FP16 accumulator: bias plus a stream of product terms, summed by a
// two-stage truncating, flush-to-zero adder, and held on a valid/ready output.
module fp16_neuron_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);
    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_NORM, S_OUT} state_t;

    state_t      state_q, state_d;
    logic        first_q, first_d;
    logic        accept;
    logic        last_q;
    logic [15:0] opa_q, opb_q, acc_q;

    logic        spec_q, spec_d;
    logic [15:0] spec_val_q, spec_val_d;
    logic        sign_q, sign_d;
    logic        sub_q, sub_d;
    logic [4:0]  eb_q, eb_d;
    logic [13:0] mb_q, mb_d;
    logic [13:0] ms_q, ms_d;
    logic [15:0] res_d;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    endfunction

    function automatic logic [15:0] ftz(input logic [15:0] x);
        return (x[14:10] == 5'd0) ? {x[15], 15'd0} : x;
    endfunction

    function automatic logic [13:0] sig14(input logic [15:0] x);
        return (x[14:10] == 5'd0) ? 14'd0 : {1'b1, x[9:0], 3'b000};
    endfunction

    // Shifted-out bits collapse into bit 0 so a later truncation still rounds toward zero.
    function automatic logic [13:0] align_rz(input logic [13:0] m, input logic [4:0] diff);
        logic [3:0]  sh;
        logic [13:0] mask;
        sh   = (diff > 5'd14) ? 4'd14 : diff[3:0];
        mask = 14'((15'd1 << sh) - 15'd1);
        return (m >> sh) | {13'd0, |(m & mask)};
    endfunction

    function automatic logic [3:0] lzc14(input logic [13:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (m[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

    function automatic logic [15:0] pack_rz(input logic s, input logic signed [6:0] e,
                                            input logic [9:0] frac);
        if (e >= 7'sd31) return {s, 5'h1F, 10'd0};
        if (e <= 7'sd0)  return 16'h0000;
        return {s, e[4:0], frac};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            first_q <= 1'b1;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            if (state_q == S_NORM) acc_q <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ALIGN;
                    first_d = 1'b0;
                end
            end
            S_ALIGN: state_d = S_NORM;
            S_NORM:  state_d = last_q ? S_OUT : S_IDLE;
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    first_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_OUT);
        accept    = in_valid && in_ready;
    end

    assign out_data = acc_q;

    // Operand capture at acceptance, stage-1 results captured at the end of ALIGN.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa_q  <= first_q ? bias : acc_q;
            opb_q  <= in_data;
            last_q <= in_last;
        end
        if (state_q == S_ALIGN) begin
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            eb_q       <= eb_d;
            mb_q       <= mb_d;
            ms_q       <= ms_d;
        end
    end

    always_comb begin
        logic [15:0] fa, fb, big, sml;
        logic        swap;
        fa   = ftz(opa_q);
        fb   = ftz(opb_q);
        swap = fb[14:0] > fa[14:0];
        big  = swap ? fb : fa;
        sml  = swap ? fa : fb;
        sign_d = big[15];
        sub_d  = big[15] ^ sml[15];
        eb_d   = big[14:10];
        mb_d   = sig14(big);
        ms_d   = align_rz(sig14(sml), big[14:10] - sml[14:10]);
        spec_d     = 1'b0;
        spec_val_d = 16'h0000;
        if (is_nan(opa_q) || is_nan(opb_q) ||
            (is_inf(opa_q) && is_inf(opb_q) && (opa_q[15] != opb_q[15]))) begin
            spec_d     = 1'b1;
            spec_val_d = 16'h7E00;
        end else if (is_inf(opa_q)) begin
            spec_d     = 1'b1;
            spec_val_d = opa_q;
        end else if (is_inf(opb_q)) begin
            spec_d     = 1'b1;
            spec_val_d = opb_q;
        end
    end

    always_comb begin
        logic [14:0]        sum;
        logic [13:0]        norm;
        logic [3:0]         lz;
        logic signed [6:0]  e_carry, e_norm;
        sum     = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});
        lz      = lzc14(sum[13:0]);
        norm    = sum[13:0] << lz;
        e_carry = $signed({2'b00, eb_q}) + 7'sd1;
        e_norm  = $signed({2'b00, eb_q}) - $signed({3'b000, lz});
        if (spec_q)
            res_d = spec_val_q;
        else if (sum == 15'd0)
            res_d = 16'h0000;
        else if (sum[14])
            res_d = pack_rz(sign_q, e_carry, 10'(sum >> 4));
        else
            res_d = pack_rz(sign_q, e_norm, 10'(norm >> 3));
    end
endmodule

// File: tb/tb_fp16_neuron_acc.sv
// Scoreboard bench for fp16_neuron_acc: directed vectors with hand-computed sums,
// then a random stream checked against an exact fixed-point truncating model.
module tb_fp16_neuron_acc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic [15:0] bias = 16'h0000;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic        dir_or = 1'b1;
    logic        rnd_or = 1'b1;
    logic        rnd_ready = 1'b0;
    logic        out_ready;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    logic [15:0] d_bias [0:10] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00,
                                   16'h3C00, 16'h0401, 16'hFBFF, 16'hFC00, 16'h3C00};
    logic [15:0] d_term [0:10] = '{16'hC400, 16'hBC00, 16'h1000, 16'hFC00, 16'h7E01, 16'h0001,
                                   16'h8400, 16'h8400, 16'hFBFF, 16'h3C00, 16'h3C00};
    logic [15:0] d_exp  [0:10] = '{16'hC200, 16'h0000, 16'h3C00, 16'h7E00, 16'h7E00, 16'h3C00,
                                   16'h3BFF, 16'h0000, 16'hFC00, 16'hFC00, 16'h4000};

    assign out_ready = rnd_ready ? rnd_or : dir_or;

    fp16_neuron_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    // Exact value scaled by 2^24; every normal FP16 is an integer in this scale.
    function automatic longint fx(input logic [15:0] x);
        longint v;
        if (x[14:10] == 5'd0) return 0;
        v = longint'({1'b1, x[9:0]}) << (int'(x[14:10]) - 1);
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        longint          s;
        longint unsigned m;
        int              p, e;
        logic            an, bn, ai, bi, neg;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (an || bn || (ai && bi && (a[15] != b[15]))) return 16'h7E00;
        if (ai) return a;
        if (bi) return b;
        s = fx(a) + fx(b);
        if (s == 0) return 16'h0000;
        neg = (s < 0);
        m = neg ? longint'(-s) : s;
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        e = p - 9;
        if (e >= 31) return {neg, 5'h1F, 10'd0};
        if (e <= 0) return 16'h0000;
        return {neg, 5'(e), 10'(m >> (p - 10))};
    endfunction

    function automatic logic [15:0] rand_fp();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 16'($urandom);
        if (r == 1) return {1'($urandom), 5'd0, 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
    endfunction

    task automatic send(input logic [15:0] b, input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        bias     = b;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        bias     = 16'h5555;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
        end
    endtask

    // Monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h required no output", out_data);
            end else begin
                check16("sum", out_data, exp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) rnd_or = ($urandom_range(0, 2) != 0);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check16("rst_out_data", out_data, 16'h0000);
        rst = 1'b0;
        #1;
        check1("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        exp_q.push_back(16'h4200);
        send(16'h0000, 16'h3C00, 1'b0);
        send(16'h4800, 16'h4000, 1'b1);
        check1("lat_e0_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check1("lat_e1_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check1("lat_e2_out_valid", out_valid, 1'b1);
        check1("lat_e2_in_ready", in_ready, 1'b0);
        wait_drain();

        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(d_exp[i]);
            send(d_bias[i], d_term[i], 1'b1);
        end
        wait_drain();

        exp_q.push_back(16'h7C00);
        send(16'h7800, 16'h7800, 1'b0);
        send(16'h3C00, 16'h0000, 1'b1);
        wait_drain();

        // Backpressure with a new vector already waiting on the input.
        exp_q.push_back(16'h4200);
        dir_or = 1'b0;
        send(16'h3C00, 16'h4000, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 16'h3C00;
        bias     = 16'h4400;
        in_last  = 1'b1;
        exp_q.push_back(16'h4500);
        repeat (5) begin
            check1("bp_out_valid", out_valid, 1'b1);
            check16("bp_out_data", out_data, 16'h4200);
            check1("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        dir_or = 1'b1;
        @(posedge clk);
        #1;
        check1("bp_release_in_ready", in_ready, 1'b1);
        check1("bp_release_out_valid", out_valid, 1'b0);
        send(16'h4400, 16'h3C00, 1'b1);
        wait_drain();

        // Reset while the last term of a three-term vector sits in NORM.
        send(16'h3C00, 16'h3C00, 1'b0);
        send(16'h3C00, 16'h3C00, 1'b0);
        send(16'h3C00, 16'h3C00, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check1("rst_mid_out_valid", out_valid, 1'b0);
        check16("rst_mid_out_data", out_data, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check1("rst_mid_out_valid_later", out_valid, 1'b0);
        exp_q.push_back(16'h4200);
        send(16'h4000, 16'h3C00, 1'b1);
        wait_drain();

        rnd_ready = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int          nt;
            logic [15:0] b, t, acc;
            nt  = $urandom_range(1, 8);
            b   = rand_fp();
            acc = b;
            for (int k = 0; k < nt; k++) begin
                t   = rand_fp();
                acc = ref_add(acc, t);
                if (k == nt - 1) exp_q.push_back(acc);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                send((k == 0) ? b : 16'($urandom), t, k == nt - 1);
            end
        end
        wait_drain();
        rnd_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded, pending=%0d required 0", exp_q.size());
        $fatal(1);
    end
endmodule
